// File: rtl/bsa_pkg.sv
// Shared types and limits for the bit-serial adder unit.
package bsa_pkg;

    // Control states: wait for operands, add one bit per cycle, hold result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bsa_state_t;

    // Supported operand width range.
    localparam int BSA_MIN_WIDTH = 2;
    localparam int BSA_MAX_WIDTH = 32;

endpackage : bsa_pkg

// File: rtl/bitserial_add_unit_ha_cell.sv
// Half adder cell; two of these plus an OR gate form the serial full adder.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : ha_cell

// File: rtl/bitserial_add_unit.sv
// Bit-serial WIDTH-bit adder: accepts an operand pair, adds one bit per cycle
// LSB first, and presents the registered sum and carry-out until taken.
module bitserial_add_unit
    import bsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    bsa_state_t       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    // Holds the WIDTH-1 sum bits already produced; the last bit joins on the way into sum_q.
    logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
    logic             c_q,      c_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;

    logic             ha0_s, ha0_c;
    logic             fa_s,  ha1_c;
    logic             fa_c;
    logic [WIDTH-1:0] sum_full;

    // Full adder on the current LSBs and the running carry.
    ha_cell u_ha0 (
        .a (a_sh_q[0]),
        .b (b_sh_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    ha_cell u_ha1 (
        .a (ha0_s),
        .b (c_q),
        .s (fa_s),
        .c (ha1_c)
    );

    assign fa_c     = ha0_c | ha1_c;
    assign sum_full = {fa_s, sum_sh_q};

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values computed by the combinational logic.
        if (rst) begin
            // NOTE: the shift registers are plain flops, not a memory, so they
            // are cleared with everything else to keep results free of stale bits.
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = SHIFT;
                    a_sh_d   = op_a;
                    b_sh_d   = op_b;
                    sum_sh_d = '0;
                    c_d      = cin;
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = sum_full[WIDTH-1:1];
                c_d      = fa_c;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    sum_d   = sum_full;
                    cout_d  = fa_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == SHIFT) || (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
    end

endmodule : bitserial_add_unit

// File: tb/tb_bitserial_add_unit.sv
// Scoreboard bench for bitserial_add_unit at WIDTH=8.
module tb_bitserial_add_unit;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int n_vec  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int n_res  = 0;

    logic [WIDTH:0] exp_q[$];

    bitserial_add_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed output handshake pops one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_res++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", {55'd0, cout, sum}, 64'h1ff00);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                check("result", {55'd0, cout, sum}, {55'd0, e});
            end
        end
    end

    // Wait (bounded) for in_ready, then present one operand pair for one cycle.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input logic push, input logic [WIDTH:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        op_a     = a;
        op_b     = b;
        cin      = ci;
        in_valid = 1'b1;
        if (push) exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        n_acc++;
    endtask

    // Consume one result, optionally with random out_ready stalls.
    task automatic drain(input logic stall);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) got = 1'b1;
            tick();
        end
        check("drain_timeout", {63'd0, got}, 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        out_ready = 1'b0;

        // 1. Reset state.
        tick();
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy",      {63'd0, busy},      64'd0);
        check("rst_sum",       {56'd0, sum},       64'h00);
        check("rst_cout",      {63'd0, cout},      64'd0);
        rst = 1'b0;
        tick();
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);

        // 2. 0x5A+0x3C: exact latency and return to IDLE.
        out_ready = 1'b1;
        send(8'h5A, 8'h3C, 1'b0, 1'b1, 9'h096);
        for (int i = 0; i < WIDTH; i++) begin
            check("lat_not_yet", {63'd0, out_valid}, 64'd0);
            tick();
        end
        check("lat_valid",      {63'd0, out_valid}, 64'd1);
        check("lat_no_bypass",  {63'd0, in_ready},  64'd0);
        tick();
        check("lat_idle_ready", {63'd0, in_ready},  64'd1);
        check("lat_idle_valid", {63'd0, out_valid}, 64'd0);

        // 3. Overflow cases.
        send(8'hFF, 8'h01, 1'b0, 1'b1, 9'h100);
        drain(1'b0);
        send(8'hFF, 8'hFF, 1'b1, 1'b1, 9'h1FF);
        drain(1'b0);

        // 4. Backpressure in DONE with ignored in_valid pulses.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b1, 1'b1, 9'h047);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            op_a     = 8'h11;
            op_b     = 8'h11;
            in_valid = i[0];
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_sum",   {56'd0, sum},       64'h47);
            check("bp_cout",  {63'd0, cout},      64'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("bp_no_capture_busy",  {63'd0, busy},      64'd0);
        check("bp_no_capture_valid", {63'd0, out_valid}, 64'd0);
        check("bp_held_sum",         {56'd0, sum},       64'h47);

        // 5. Reset during SHIFT discards the operation; no stale carry afterwards.
        send(8'hF0, 8'hF0, 1'b1, 1'b0, 9'h000);
        n_acc--;
        for (int i = 0; i < 3; i++) tick();
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        check("abort_busy",     {63'd0, busy},      64'd0);
        check("abort_valid",    {63'd0, out_valid}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready},  64'd1);
        check("abort_sum",      {56'd0, sum},       64'h00);
        check("abort_cout",     {63'd0, cout},      64'd0);
        rst = 1'b0;
        tick();
        send(8'h01, 8'h02, 1'b0, 1'b1, 9'h003);
        drain(1'b0);

        // 6. Random sweep with random output stalls.
        for (int k = 0; k < 1000; k++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rc;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rc, 1'b1, {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc});
            drain(1'b1);
        end
        out_ready = 1'b0;
        tick();
        tick();

        check("results_eq_accepts", 64'(n_res), 64'(n_acc));
        check("queue_empty",        64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_bitserial_add_unit
